// File: rtl/aes_pkg.sv
// Shared AES constants, InvMixColumns FSM encoding and GF(2^8) helpers.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam logic [7:0] COEF_0E = 8'h0E;
    localparam logic [7:0] COEF_0B = 8'h0B;
    localparam logic [7:0] COEF_0D = 8'h0D;
    localparam logic [7:0] COEF_09 = 8'h09;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Constant multiply as a chain of xtime doublings; c is a synthesis-time constant.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] pow;
        acc = 8'h00;
        pow = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ pow;
            pow = xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column; byte r of the column is row r.
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[7:0];
    assign a1 = col_in[15:8];
    assign a2 = col_in[23:16];
    assign a3 = col_in[31:24];

    assign col_out[7:0]   = gf_mul_const(a0, COEF_0E) ^ gf_mul_const(a1, COEF_0B)
                          ^ gf_mul_const(a2, COEF_0D) ^ gf_mul_const(a3, COEF_09);
    assign col_out[15:8]  = gf_mul_const(a0, COEF_09) ^ gf_mul_const(a1, COEF_0E)
                          ^ gf_mul_const(a2, COEF_0B) ^ gf_mul_const(a3, COEF_0D);
    assign col_out[23:16] = gf_mul_const(a0, COEF_0D) ^ gf_mul_const(a1, COEF_09)
                          ^ gf_mul_const(a2, COEF_0E) ^ gf_mul_const(a3, COEF_0B);
    assign col_out[31:24] = gf_mul_const(a0, COEF_0B) ^ gf_mul_const(a1, COEF_0D)
                          ^ gf_mul_const(a2, COEF_09) ^ gf_mul_const(a3, COEF_0E);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
//   state   | meaning
//   IDLE    | waiting for a block, in_ready high once out of reset
//   CALC    | transforming columns col_cnt.. in the work register
//   DONE    | result on out_state, held until out_ready
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]   state;
    logic [1:0]   col_cnt;
    logic [127:0] work;
    logic [127:0] work_next;
    logic         ready_en;
    logic         accept;

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = col_cnt + 2'(g);
        assign col_in[g]  = work[{col_idx[g], 5'b0} +: 32];

        inv_mix_column u_col (
            .col_in  (col_in[g]),
            .col_out (col_out[g])
        );
    end

    always_comb begin
        work_next = work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_next[{col_idx[g], 5'b0} +: 32] = col_out[g];
        end
    end

    // ready_en keeps in_ready low until the first edge after reset release.
    assign in_ready  = ready_en & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            col_cnt   <= 2'd0;
            work      <= '0;
            out_state <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        work    <= in_state;
                        col_cnt <= 2'd0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    work <= work_next;
                    if (col_cnt == LAST_COL) begin
                        out_state <= work_next;
                        col_cnt   <= 2'd0;
                        state     <= ST_DONE;
                    end else begin
                        col_cnt <= col_cnt + COL_STEP;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            work    <= in_state;
                            col_cnt <= 2'd0;
                            state   <= ST_CALC;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
